usb_protocol: RTL and testbench

USB_PROTOCOL -- requirements
Module: usb_protocol

---
 rtl/usb_protocol.sv | 202 ++++++++++++++++++++
 tb/tb_usb_protocol.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_protocol.sv
// USB device-side protocol FSM (Moore). Decodes host PIDs, sequences OUT
// (receive) and IN (transmit) transactions, and steers the transmitter.
// Optional build macro USB_PROTOCOL_TIMEOUT_EN adds an inactivity timeout
// to the RX, RX_DATA, RX_ERR and TX_WAIT_ACK states.
module usb_protocol (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] rx_packet,
   input  logic       buffer_reserved,
   input  logic [6:0] tx_packet_data_size,
   input  logic [6:0] buffer_occupancy,
   input  logic       tx_busy,
   output logic       d_mode,
   output logic [1:0] tx_packet,
   output logic       clear,
   output logic       tx_error,
   output logic       rx_error,
   output logic       rx_data_ready,
   output logic       rx_transfer_active,
   output logic       tx_transfer_active
);

   localparam logic [3:0] PID_NONE  = 4'b0000;
   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_EOP   = 4'b1111;

   typedef enum logic [3:0] {
      S_IDLE,
      S_RX,
      S_RX_DATA,
      S_RX_ERR,
      S_SEND_ACK,
      S_SEND_NAK,
      S_TX_DATA,
      S_TX_WAIT_ACK,
      S_TX_NAK
   } state_t;

   state_t state_q, state_d;
   logic   started_q, started_d;
   logic   clear_q, clear_d;
   logic   txerr_q, txerr_d;
   logic   rxerr_q, rxerr_d;
   logic   timeout;
   logic   is_wait;

`ifdef USB_PROTOCOL_TIMEOUT_EN
   logic [6:0] cnt_q, cnt_d;

   assign timeout = (cnt_q == 7'd64);

   // Inactivity counter: restarts on any state change or bus activity, saturates
   always_comb begin
      cnt_d = cnt_q;
      if ((state_d != state_q) || (rx_packet != PID_NONE))
         cnt_d = '0;
      else if (cnt_q != 7'd127)
         cnt_d = cnt_q + 7'd1;
   end

   // Timeout counter register
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   // State register plus registered one-cycle pulse flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         started_q <= 1'b0;
         clear_q   <= 1'b0;
         txerr_q   <= 1'b0;
         rxerr_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         started_q <= started_d;
         clear_q   <= clear_d;
         txerr_q   <= txerr_d;
         rxerr_q   <= rxerr_d;
      end
   end

   // Next-state logic; error pulses are registered so outputs stay Moore
   always_comb begin
      state_d = state_q;
      txerr_d = 1'b0;
      rxerr_d = 1'b0;
      is_wait = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rx_packet == PID_OUT)
               state_d = buffer_reserved ? S_RX_ERR : S_RX;
            else if (rx_packet == PID_IN)
               state_d = (buffer_reserved || (buffer_occupancy < tx_packet_data_size))
                         ? S_TX_NAK : S_TX_DATA;
         end
         // Timeout only fires on an idle bus cycle; any PID counts as activity
         S_RX: begin
            if (rx_packet == PID_NONE) begin
               if (timeout) begin
                  state_d = S_IDLE;
                  rxerr_d = 1'b1;
               end
            end else if ((rx_packet == PID_DATA0) || (rx_packet == PID_DATA1))
               state_d = S_RX_DATA;
            else
               state_d = S_RX_ERR;
         end
         S_RX_DATA: begin
            if (rx_packet == PID_NONE) begin
               if (timeout) begin
                  state_d = S_IDLE;
                  rxerr_d = 1'b1;
               end
            end else if (rx_packet == PID_EOP)
               state_d = S_SEND_ACK;
            else
               state_d = S_RX_ERR;
         end
         S_RX_ERR: begin
            if (rx_packet == PID_EOP)
               state_d = S_SEND_NAK;
            else if ((rx_packet == PID_NONE) && timeout) begin
               state_d = S_IDLE;
               rxerr_d = 1'b1;
            end
         end
         S_SEND_ACK, S_SEND_NAK, S_TX_NAK: begin
            is_wait = 1'b1;
            if (started_q && !tx_busy)
               state_d = S_IDLE;
         end
         S_TX_DATA: begin
            is_wait = 1'b1;
            if (started_q && !tx_busy)
               state_d = S_TX_WAIT_ACK;
         end
         S_TX_WAIT_ACK: begin
            if (rx_packet == PID_ACK)
               state_d = S_IDLE;
            else if (rx_packet == PID_NONE) begin
               if (timeout) begin
                  state_d = S_IDLE;
                  txerr_d = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
               txerr_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      started_d = (is_wait && (state_d == state_q)) ? (started_q | tx_busy) : 1'b0;
      clear_d   = (state_d == S_RX) && (state_q != S_RX);
   end

   // Output decode from registered state and registered pulse flags
   always_comb begin
      d_mode             = 1'b0;
      tx_packet          = 2'b00;
      clear              = clear_q;
      tx_error           = txerr_q;
      rx_error           = rxerr_q;
      rx_data_ready      = 1'b0;
      rx_transfer_active = 1'b0;
      tx_transfer_active = 1'b0;
      case (state_q)
         S_RX, S_RX_DATA: rx_transfer_active = 1'b1;
         S_SEND_ACK: begin
            d_mode        = 1'b1;
            tx_packet     = 2'b00;
            rx_data_ready = 1'b1;
         end
         S_SEND_NAK: begin
            d_mode    = 1'b1;
            tx_packet = 2'b01;
            rx_error  = 1'b1;
         end
         S_TX_NAK: begin
            d_mode    = 1'b1;
            tx_packet = 2'b01;
            tx_error  = 1'b1;
         end
         S_TX_DATA: begin
            d_mode             = 1'b1;
            tx_packet          = 2'b10;
            tx_transfer_active = 1'b1;
         end
         S_TX_WAIT_ACK: tx_transfer_active = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_usb_protocol.sv
// Directed testbench for usb_protocol. Outputs are packed as
// {d_mode, tx_packet[1:0], clear, tx_error, rx_error, rx_data_ready,
//  rx_transfer_active, tx_transfer_active}.
module tb_usb_protocol;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] rx_packet;
   logic       buffer_reserved;
   logic [6:0] tx_packet_data_size;
   logic [6:0] buffer_occupancy;
   logic       tx_busy;
   logic       d_mode;
   logic [1:0] tx_packet;
   logic       clear, tx_error, rx_error, rx_data_ready;
   logic       rx_transfer_active, tx_transfer_active;
   logic [8:0] outs;

   int tests_run = 0;
   int fails = 0;

   localparam logic [8:0] O_IDLE  = 9'b0_00_000000;
   localparam logic [8:0] O_RX1   = 9'b0_00_100010;
   localparam logic [8:0] O_RX    = 9'b0_00_000010;
   localparam logic [8:0] O_RXERR = 9'b0_00_000000;
   localparam logic [8:0] O_ACK   = 9'b1_00_000100;
   localparam logic [8:0] O_SNAK  = 9'b1_01_001000;
   localparam logic [8:0] O_TNAK  = 9'b1_01_010000;
   localparam logic [8:0] O_TXD   = 9'b1_10_000001;
   localparam logic [8:0] O_TWAIT = 9'b0_00_000001;
   localparam logic [8:0] O_TXEP  = 9'b0_00_010000;

   usb_protocol dut (
      .clk                 (clk),
      .rst                 (rst),
      .rx_packet           (rx_packet),
      .buffer_reserved     (buffer_reserved),
      .tx_packet_data_size (tx_packet_data_size),
      .buffer_occupancy    (buffer_occupancy),
      .tx_busy             (tx_busy),
      .d_mode              (d_mode),
      .tx_packet           (tx_packet),
      .clear               (clear),
      .tx_error            (tx_error),
      .rx_error            (rx_error),
      .rx_data_ready       (rx_data_ready),
      .rx_transfer_active  (rx_transfer_active),
      .tx_transfer_active  (tx_transfer_active)
   );

   always #5 clk = ~clk;

   assign outs = {d_mode, tx_packet, clear, tx_error, rx_error,
                  rx_data_ready, rx_transfer_active, tx_transfer_active};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] pid);
      rx_packet = pid;
      step();
      rx_packet = 4'b0000;
   endtask

   task automatic busy_cycle();
      tx_busy = 1'b1;
      step();
      tx_busy = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      tests_run++;
      if (outs !== O_IDLE) begin
         fails++;
         $display("FAIL reset_outputs: got %b expected %b", outs, O_IDLE);
      end
      rst = 1'b0;
      send(4'b0001);
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests_run++;
      if (outs !== O_IDLE) begin
         fails++;
         $display("FAIL reset_mid_rx: got %b expected %b", outs, O_IDLE);
      end
      send(4'b1001);
      tx_busy = 1'b1;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      tx_busy = 1'b0;
      step();
      tests_run++;
      if (outs !== O_IDLE) begin
         fails++;
         $display("FAIL reset_mid_tx: got %b expected %b", outs, O_IDLE);
      end
   endtask

   task automatic test_idle_ignore();
      send(4'b0011);
      send(4'b0010);
      send(4'b1111);
      send(4'b0101);
      tests_run++;
      if (outs !== O_IDLE) begin
         fails++;
         $display("FAIL idle_ignore: got %b expected %b", outs, O_IDLE);
      end
   endtask

   task automatic test_out_good();
      send(4'b0001);
      tests_run++;
      if (outs !== O_RX1) begin
         fails++;
         $display("FAIL out_first: got %b expected %b", outs, O_RX1);
      end
      send(4'b0000);
      tests_run++;
      if (outs !== O_RX) begin
         fails++;
         $display("FAIL out_clear_once: got %b expected %b", outs, O_RX);
      end
      send(4'b0011);
      tests_run++;
      if (outs !== O_RX) begin
         fails++;
         $display("FAIL out_data0: got %b expected %b", outs, O_RX);
      end
      send(4'b1111);
      tests_run++;
      if (outs !== O_ACK) begin
         fails++;
         $display("FAIL out_ack: got %b expected %b", outs, O_ACK);
      end
      step();
      tests_run++;
      if (outs !== O_ACK) begin
         fails++;
         $display("FAIL ack_holds_no_busy: got %b expected %b", outs, O_ACK);
      end
      tx_busy = 1'b1;
      step();
      tests_run++;
      if (outs !== O_ACK) begin
         fails++;
         $display("FAIL ack_holds_busy: got %b expected %b", outs, O_ACK);
      end
      tx_busy = 1'b0;
      step();
      tests_run++;
      if (outs !== O_IDLE) begin
         fails++;
         $display("FAIL ack_done: got %b expected %b", outs, O_IDLE);
      end
   endtask

   task automatic test_out_bad_pid();
      send(4'b0001);
      send(4'b1100);
      tests_run++;
      if (outs !== O_RXERR) begin
         fails++;
         $display("FAIL out_bad_rxerr: got %b expected %b", outs, O_RXERR);
      end
      send(4'b1111);
      tests_run++;
      if (outs !== O_SNAK) begin
         fails++;
         $display("FAIL out_bad_nak: got %b expected %b", outs, O_SNAK);
      end
      busy_cycle();
      tests_run++;
      if (outs !== O_IDLE) begin
         fails++;
         $display("FAIL out_bad_done: got %b expected %b", outs, O_IDLE);
      end
      // DATA1 accepted, then a second DATA PID instead of EOP is an error
      send(4'b0001);
      send(4'b1011);
      send(4'b1011);
      send(4'b1111);
      tests_run++;
      if (outs !== O_SNAK) begin
         fails++;
         $display("FAIL out_double_data: got %b expected %b", outs, O_SNAK);
      end
      busy_cycle();
   endtask

   task automatic test_out_reserved();
      buffer_reserved = 1'b1;
      send(4'b0001);
      buffer_reserved = 1'b0;
      send(4'b0000);
      send(4'b0011);
      tests_run++;
      if (outs !== O_RXERR) begin
         fails++;
         $display("FAIL out_res_wait: got %b expected %b", outs, O_RXERR);
      end
      send(4'b1111);
      tests_run++;
      if (outs !== O_SNAK) begin
         fails++;
         $display("FAIL out_res_nak: got %b expected %b", outs, O_SNAK);
      end
      busy_cycle();
   endtask

   task automatic test_in();
      buffer_occupancy    = 7'd0;
      tx_packet_data_size = 7'd0;
      send(4'b1001);
      tests_run++;
      if (outs !== O_TXD) begin
         fails++;
         $display("FAIL in_data: got %b expected %b", outs, O_TXD);
      end
      busy_cycle();
      tests_run++;
      if (outs !== O_TWAIT) begin
         fails++;
         $display("FAIL in_wait_ack: got %b expected %b", outs, O_TWAIT);
      end
      send(4'b0000);
      send(4'b0010);
      tests_run++;
      if (outs !== O_IDLE) begin
         fails++;
         $display("FAIL in_acked: got %b expected %b", outs, O_IDLE);
      end
      send(4'b1001);
      busy_cycle();
      send(4'b1011);
      tests_run++;
      if (outs !== O_TXEP) begin
         fails++;
         $display("FAIL in_bad_ack_pulse: got %b expected %b", outs, O_TXEP);
      end
      step();
      tests_run++;
      if (outs !== O_IDLE) begin
         fails++;
         $display("FAIL in_pulse_one_cycle: got %b expected %b", outs, O_IDLE);
      end
      buffer_reserved = 1'b1;
      send(4'b1001);
      buffer_reserved = 1'b0;
      tests_run++;
      if (outs !== O_TNAK) begin
         fails++;
         $display("FAIL in_reserved_nak: got %b expected %b", outs, O_TNAK);
      end
      busy_cycle();
      tests_run++;
      if (outs !== O_IDLE) begin
         fails++;
         $display("FAIL in_nak_done: got %b expected %b", outs, O_IDLE);
      end
   endtask

   task automatic test_occupancy_bounds();
      logic [6:0] occ_v  [4] = '{7'd10, 7'd9,  7'd127, 7'd5};
      logic [6:0] size_v [4] = '{7'd10, 7'd10, 7'd100, 7'd100};
      logic [8:0] exp_v  [4] = '{O_TXD, O_TNAK, O_TXD, O_TNAK};
      for (int i = 0; i < 4; i++) begin
         buffer_occupancy    = occ_v[i];
         tx_packet_data_size = size_v[i];
         send(4'b1001);
         tests_run++;
         if (outs !== exp_v[i]) begin
            fails++;
            $display("FAIL occ_bound_%0d: occ=%0d size=%0d got %b expected %b",
                     i, occ_v[i], size_v[i], outs, exp_v[i]);
         end
         busy_cycle();
         if (exp_v[i] == O_TXD) send(4'b0010);
      end
   endtask

`ifdef USB_PROTOCOL_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      n = 0;
      send(4'b0001);
      for (int i = 1; i <= 80; i++) begin
         step();
         if (rx_error === 1'b1 && n == 0) n = i;
      end
      tests_run++;
      if (n != 65) begin
         fails++;
         $display("FAIL rx_timeout_cycle: got %0d expected 65", n);
      end
   endtask
`endif

   initial begin
      rst                 = 1'b1;
      rx_packet           = 4'b0000;
      buffer_reserved     = 1'b0;
      tx_packet_data_size = 7'd0;
      buffer_occupancy    = 7'd0;
      tx_busy             = 1'b0;
      test_reset();
      test_idle_ignore();
      test_out_good();
      test_out_bad_pid();
      test_out_reserved();
      test_in();
      test_occupancy_bounds();
`ifdef USB_PROTOCOL_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
